vbus_arbiter: RTL and testbench
===============================

Name: vbus_arbiter

Overview:
- Two-port arbiter and sequencer for the shared serial data SRAM behind the virtual bus.
- Accepts 32-bit read/write requests from the instruction port (port I) and the data port (port D), grants one at a time with round-robin, and splits each word into two 36-bit half-word frames (low half, then high half).
- Reassembles the two 16-bit read responses into one 32-bit word and returns it with a one-cycle ack.
- Addresses outside the SRAM region complete without touching the SRAM and flag an error.

Parameters:
- REGION, 12'h001, value of addr[31:20] that selects the SRAM; anything else is out-of-region.

Ports:
- sck  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  port I request, held high until i_ack
- i_rw  in  1  port I: 1 = write, 0 = read
- i_addr  in  32  port I byte address (bits [1:0] ignored)
- i_wdata  in  32  port I write data
- i_ack  out  1  port I one-cycle completion pulse
- i_err  out  1  port I out-of-region flag, valid with i_ack
- i_rdata  out  32  port I read data, valid with i_ack
- d_req, d_rw, d_addr, d_wdata, d_ack, d_err, d_rdata: same as port I, for port D
- sram_cs_n  out  1  SRAM select, active-low
- sram_mosi  out  36  frame {rw, wdata16, addr[19:2], half}; half = 0 for the low half, 1 for the high half
- sram_miso  in  16  SRAM response; carries the read data for the frame driven in the previous cycle
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: i_ack, d_ack, i_err, d_err = 0; i_rdata, d_rdata = 0; sram_cs_n = 1; sram_mosi = 0; state = IDLE; last_grant = I.
- States: IDLE, LO, HI, TAIL, ACK.
- IDLE:
  - Sample i_req and d_req.
  - If only one is high, grant it.
  - If both are high, grant the port not granted last. Because last_grant resets to I, the first tie after reset goes to D.
  - On grant, latch rw, addr and wdata, and update last_grant.
  - In-region grant: go to LO.
  - Out-of-region grant: go to ACK with err = 1 and rdata = 0.
  - No request: stay in IDLE.
- LO: sram_cs_n = 0; mosi = {rw, wdata[15:0], addr[19:2], 0}; go to HI.
- HI:
  - sram_cs_n = 0; mosi = {rw, wdata[31:16], addr[19:2], 1}.
  - Capture sram_miso into rd_lo when rw = 0.
  - Go to TAIL.
- TAIL: sram_cs_n = 1; capture sram_miso into rd_hi when rw = 0; go to ACK.
- ACK:
  - Pulse ack for one cycle on the granted port only.
  - rdata = {rd_hi, rd_lo} for an in-region read; 0 for writes and errors.
  - The other port's ack stays 0.
  - Go to IDLE.
- Latency:
  - In-region request sampled at cycle T: ack asserted during T+4.
  - Out-of-region request: ack during T+1.
  - Earliest next grant: T+5 (in-region) or T+2 (out-of-region).
- Outputs are registered. rdata and err hold their values until the next ack on the same port. mosi holds its last frame while cs_n = 1.
- Requester rule: drop req in the cycle after ack. A req that is still high in IDLE is treated as a new request.
- Requests arriving during non-IDLE states wait; they are not lost, because req is level-held.
- Request inputs are ignored outside IDLE; latched fields are never re-sampled mid-transaction.
- Writes drive both frames; sram_miso is ignored.
- rst in any state: next cycle is IDLE with reset outputs. No partial frame or ack is emitted afterwards. A frame already driven is not retracted.

Decomposition:
- Package vbus_pkg:
  - state encoding enum
  - frame field offsets (RW_BIT = 35, DATA [34:19], ADDR [18:1], HALF_BIT = 0)
  - SRAM region constant
  - port index constants PORT_I = 0, PORT_D = 1
- Sub-module rr_arb2: two-request round-robin arbiter.
  - Inputs: req[1:0], last, enable.
  - Outputs: gnt[1:0], gnt_idx.
  - Purely combinational; last_grant is held in the parent.

Test Plan:
- In-region read:
  - Stimulus: d_req, read, d_addr = 0x0010_0008; SRAM model returns 0xBEEF for the LO frame and 0xDEAD for the HI frame.
  - Required: mosi = {0, 0x0000, 18'h2, 0} then {0, 0x0000, 18'h2, 1}; d_ack at T+4 with d_rdata = 0xDEADBEEF, d_err = 0; i_ack stays 0.
- In-region write:
  - Stimulus: i_req, write, i_addr = 0x0010_0004, i_wdata = 0x12345678.
  - Required: frames {1, 0x5678, 18'h1, 0} then {1, 0x1234, 18'h1, 1}; cs_n low for exactly 2 cycles; i_ack at T+4; i_rdata = 0.
- Out-of-region:
  - Stimulus: d_req, read, d_addr = 0x0020_0000.
  - Required: cs_n stays 1 throughout; d_ack at T+1 with d_err = 1, d_rdata = 0.
- Ties and back-to-back:
  - Stimulus: both ports request in-region reads continuously after reset.
  - Required: grant order D, I, D, I; each ack spaced 5 cycles apart; no overlapping frames.
- Reset in HI:
  - Stimulus: assert rst during the HI state of a read.
  - Required: next cycle IDLE, cs_n = 1, no ack; a request re-issued after rst completes normally with correct data.
- Late contender:
  - Stimulus: i_req rises during the LO state of a port D transaction.
  - Required: port I is granted in the IDLE cycle right after d_ack; port I data correct.

Source files
------------

// File: rtl/vbus_pkg.sv
// Shared types and constants for the virtual-bus SRAM arbiter.
package vbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_TAIL = 3'd3,
    ST_ACK  = 3'd4
  } state_t;

  // SRAM frame layout: {rw, data16, word_addr18, half}
  localparam int unsigned FRAME_W  = 36;
  localparam int unsigned RW_BIT   = 35;
  localparam int unsigned DATA_MSB = 34;
  localparam int unsigned DATA_LSB = 19;
  localparam int unsigned ADDR_MSB = 18;
  localparam int unsigned ADDR_LSB = 1;
  localparam int unsigned HALF_BIT = 0;

  // addr[31:20] value that selects the SRAM
  localparam logic [11:0] SRAM_REGION = 12'h001;

  // Port indices, also used as req/gnt bit positions
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  function automatic logic [FRAME_W-1:0] make_frame(
    input logic        rw,
    input logic [15:0] data,
    input logic [17:0] word_addr,
    input logic        half
  );
    logic [FRAME_W-1:0] f;
    f                    = '0;
    f[RW_BIT]            = rw;
    f[DATA_MSB:DATA_LSB] = data;
    f[ADDR_MSB:ADDR_LSB] = word_addr;
    f[HALF_BIT]          = half;
    return f;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the last-grant history lives in the parent.
module rr_arb2
  import vbus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // Pick the lone requester, or on a tie the one not granted last time.
  always_comb begin
    gnt     = '0;
    gnt_idx = PORT_I;
    if (enable) begin
      case (req)
        2'b01:   gnt_idx = PORT_I;
        2'b10:   gnt_idx = PORT_D;
        2'b11:   gnt_idx = ~last;
        default: gnt_idx = PORT_I;
      endcase
      if (req != 2'b00) begin
        gnt = (gnt_idx == PORT_D) ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

// File: rtl/vbus_arbiter.sv
// Arbitrates ports I and D onto the serial data SRAM, splitting each 32-bit
// access into low/high 16-bit frames and reassembling read data.
module vbus_arbiter
  import vbus_pkg::*;
#(
  parameter logic [11:0] REGION = SRAM_REGION
) (
  input  logic        sck,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_rw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        sram_cs_n,
  output logic [35:0] sram_mosi,
  input  logic [15:0] sram_miso,
  output logic        busy
);

  state_t state, next_state;

  logic        last_grant;
  logic [1:0]  gnt;
  logic        gnt_idx;
  logic        grant;

  logic        sel_rw;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_in_region;

  logic        lat_rw;
  logic [17:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [15:0] rd_lo;

  logic        ack_fire;
  logic        ack_err;
  logic [31:0] ack_data;
  logic        ack_port;

  logic        cs_n_nxt;
  logic [35:0] mosi_nxt;
  logic        i_ack_nxt, d_ack_nxt;
  logic        i_err_nxt, d_err_nxt;
  logic [31:0] i_rdata_nxt, d_rdata_nxt;

  logic        unused_addr_bits;

  rr_arb2 u_arb (
    .req    ({d_req, i_req}),
    .last   (last_grant),
    .enable (state == ST_IDLE),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign grant         = |gnt;
  assign sel_rw        = (gnt_idx == PORT_D) ? d_rw    : i_rw;
  assign sel_addr      = (gnt_idx == PORT_D) ? d_addr  : i_addr;
  assign sel_wdata     = (gnt_idx == PORT_D) ? d_wdata : i_wdata;
  assign sel_in_region = (sel_addr[31:20] == REGION);
  assign busy          = (state != ST_IDLE);

  // Byte-lane bits carry no meaning for word accesses.
  assign unused_addr_bits = ^sel_addr[1:0];

  // State register.
  always_ff @(posedge sck) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the values every registered output takes at the next edge.
  // Frames and acks are computed one state early so they appear registered
  // in the cycle the FSM enters LO/HI/ACK.
  always_comb begin
    next_state = state;
    cs_n_nxt   = 1'b1;
    mosi_nxt   = sram_mosi;
    ack_fire   = 1'b0;
    ack_port   = last_grant;
    ack_err    = 1'b0;
    ack_data   = '0;

    case (state)
      ST_IDLE: begin
        if (grant) begin
          if (sel_in_region) begin
            next_state = ST_LO;
            cs_n_nxt   = 1'b0;
            mosi_nxt   = make_frame(sel_rw, sel_wdata[15:0], sel_addr[19:2], 1'b0);
          end else begin
            next_state = ST_ACK;
            ack_fire   = 1'b1;
            ack_port   = gnt_idx;
            ack_err    = 1'b1;
          end
        end
      end
      ST_LO: begin
        next_state = ST_HI;
        cs_n_nxt   = 1'b0;
        mosi_nxt   = make_frame(lat_rw, lat_wdata[31:16], lat_addr, 1'b1);
      end
      ST_HI: begin
        next_state = ST_TAIL;
      end
      ST_TAIL: begin
        // High half is taken straight from sram_miso into the ack register,
        // standing in for a separate rd_hi flop.
        next_state = ST_ACK;
        ack_fire   = 1'b1;
        ack_data   = lat_rw ? 32'h0 : {sram_miso, rd_lo};
      end
      ST_ACK: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    i_ack_nxt   = ack_fire && (ack_port == PORT_I);
    d_ack_nxt   = ack_fire && (ack_port == PORT_D);
    i_err_nxt   = i_ack_nxt ? ack_err  : i_err;
    d_err_nxt   = d_ack_nxt ? ack_err  : d_err;
    i_rdata_nxt = i_ack_nxt ? ack_data : i_rdata;
    d_rdata_nxt = d_ack_nxt ? ack_data : d_rdata;
  end

  // Registered outputs, latched request fields and the low-half read capture.
  always_ff @(posedge sck) begin
    if (rst) begin
      sram_cs_n  <= 1'b1;
      sram_mosi  <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_err      <= 1'b0;
      d_err      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      last_grant <= PORT_I;
      lat_rw     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rd_lo      <= '0;
    end else begin
      sram_cs_n <= cs_n_nxt;
      sram_mosi <= mosi_nxt;
      i_ack     <= i_ack_nxt;
      d_ack     <= d_ack_nxt;
      i_err     <= i_err_nxt;
      d_err     <= d_err_nxt;
      i_rdata   <= i_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      if ((state == ST_IDLE) && grant) begin
        last_grant <= gnt_idx;
        lat_rw     <= sel_rw;
        lat_addr   <= sel_addr[19:2];
        lat_wdata  <= sel_wdata;
      end
      if ((state == ST_HI) && !lat_rw) begin
        rd_lo <= sram_miso;
      end
    end
  end

endmodule

// File: tb/tb_vbus_arbiter.sv
// Randomised self-checking bench for vbus_arbiter with a transaction-level
// reference model and a behavioural serial SRAM.
module tb_vbus_arbiter;

  logic        sck = 1'b0;
  logic        rst;
  logic        i_req, i_rw, d_req, d_rw;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_ack, i_err, d_ack, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        sram_cs_n;
  logic [35:0] sram_mosi;
  logic [15:0] sram_miso;
  logic        busy;

  always #5 sck = ~sck;

  vbus_arbiter #(.REGION(12'h001)) dut (
    .sck(sck), .rst(rst),
    .i_req(i_req), .i_rw(i_rw), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .sram_cs_n(sram_cs_n), .sram_mosi(sram_mosi), .sram_miso(sram_miso),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- memories: SRAM environment and reference copy ----------
  logic [15:0] sram_mem [logic [18:0]];
  logic [15:0] ref_mem  [logic [18:0]];
  logic [15:0] resp_pending = 16'h0;

  function automatic logic [15:0] init_word(input logic [18:0] k);
    return k[15:0] ^ 16'h5A3C ^ {k[18:16], 13'h0};
  endfunction

  function automatic logic [15:0] sram_rd(input logic [18:0] k);
    return sram_mem.exists(k) ? sram_mem[k] : init_word(k);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [18:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
  endfunction

  // ---------------- reference model: schedule of future events -------------
  bit          s_frame_v [8];
  logic [35:0] s_frame   [8];
  bit          s_ack_v   [8];
  bit          s_ack_p   [8];
  bit          s_ack_err [8];
  logic [31:0] s_ack_data[8];

  int          free_at   = 0;
  int          grant_cyc = 0;
  bit          m_last    = 1'b0;
  bit          m_grant_port = 1'b0;
  logic [35:0] last_frame = '0;
  logic        exp_i_err = 1'b0, exp_d_err = 1'b0;
  logic [31:0] exp_i_rdata = '0, exp_d_rdata = '0;

  bit          ack_seen [2];
  int          ack_cyc  [2];
  bit          ack_order[$];
  int          ack_times[$];
  int          cs_low_cnt = 0;

  // Decide what the edge at the end of the current cycle does.
  task automatic model_step();
    bit          p;
    logic        rw;
    logic [31:0] a, w;
    logic [17:0] wa;
    if (rst) begin
      for (int j = 0; j < 8; j++) begin
        s_frame_v[j] = 1'b0;
        s_ack_v[j]   = 1'b0;
      end
      m_last      = 1'b0;
      exp_i_err   = 1'b0;
      exp_d_err   = 1'b0;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      last_frame  = '0;
      free_at     = cyc + 1;
      grant_cyc   = cyc;
    end else if (cyc >= free_at && (i_req || d_req)) begin
      p  = (i_req && d_req) ? !m_last : d_req;
      m_last       = p;
      m_grant_port = p;
      rw = p ? d_rw    : i_rw;
      a  = p ? d_addr  : i_addr;
      w  = p ? d_wdata : i_wdata;
      grant_cyc = cyc;
      if (a[31:20] == 12'h001) begin
        wa = a[19:2];
        s_frame_v[(cyc+1)%8]  = 1'b1;
        s_frame[(cyc+1)%8]    = {rw, w[15:0], wa, 1'b0};
        s_frame_v[(cyc+2)%8]  = 1'b1;
        s_frame[(cyc+2)%8]    = {rw, w[31:16], wa, 1'b1};
        s_ack_v[(cyc+4)%8]    = 1'b1;
        s_ack_p[(cyc+4)%8]    = p;
        s_ack_err[(cyc+4)%8]  = 1'b0;
        s_ack_data[(cyc+4)%8] = rw ? 32'h0 : {ref_rd({wa, 1'b1}), ref_rd({wa, 1'b0})};
        free_at = cyc + 5;
      end else begin
        s_ack_v[(cyc+1)%8]    = 1'b1;
        s_ack_p[(cyc+1)%8]    = p;
        s_ack_err[(cyc+1)%8]  = 1'b1;
        s_ack_data[(cyc+1)%8] = 32'h0;
        free_at = cyc + 2;
      end
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_cycle();
    int   k;
    logic e_cs_n, e_iack, e_dack, e_busy;
    k      = cyc % 8;
    e_cs_n = 1'b1;
    if (s_frame_v[k]) begin
      e_cs_n     = 1'b0;
      last_frame = s_frame[k];
      if (last_frame[35]) ref_mem[{last_frame[18:1], last_frame[0]}] = last_frame[34:19];
    end
    e_iack = s_ack_v[k] && (s_ack_p[k] == 1'b0);
    e_dack = s_ack_v[k] && (s_ack_p[k] == 1'b1);
    if (e_iack) begin exp_i_err = s_ack_err[k]; exp_i_rdata = s_ack_data[k]; end
    if (e_dack) begin exp_d_err = s_ack_err[k]; exp_d_rdata = s_ack_data[k]; end
    e_busy = (cyc > grant_cyc) && (cyc < free_at);

    check_eq("cs_n",    sram_cs_n, e_cs_n);
    check_eq("mosi",    sram_mosi, last_frame);
    check_eq("i_ack",   i_ack,     e_iack);
    check_eq("d_ack",   d_ack,     e_dack);
    check_eq("i_err",   i_err,     exp_i_err);
    check_eq("d_err",   d_err,     exp_d_err);
    check_eq("i_rdata", i_rdata,   exp_i_rdata);
    check_eq("d_rdata", d_rdata,   exp_d_rdata);
    check_eq("busy",    busy,      e_busy);

    if (sram_cs_n === 1'b0) cs_low_cnt++;
    if (s_ack_v[k]) begin
      ack_seen[s_ack_p[k]] = 1'b1;
      ack_cyc[s_ack_p[k]]  = cyc;
      ack_order.push_back(s_ack_p[k]);
      ack_times.push_back(cyc);
      if (s_ack_p[k]) d_req = 1'b0;
      else            i_req = 1'b0;
    end
    s_frame_v[k] = 1'b0;
    s_ack_v[k]   = 1'b0;
  endtask

  // Serial SRAM: answers a read frame one cycle later, writes on the frame.
  task automatic sram_service();
    logic [18:0] key;
    sram_miso    = resp_pending;
    resp_pending = 16'($urandom);
    if (sram_cs_n === 1'b0) begin
      key = {sram_mosi[18:1], sram_mosi[0]};
      if (sram_mosi[35]) sram_mem[key] = sram_mosi[34:19];
      else               resp_pending  = sram_rd(key);
    end
  endtask

  task automatic advance();
    model_step();
    @(negedge sck);
    cyc++;
    check_cycle();
    sram_service();
  endtask

  task automatic issue(input bit p, input logic rw, input logic [31:0] a, input logic [31:0] w);
    if (p) begin d_req = 1'b1; d_rw = rw; d_addr = a; d_wdata = w; end
    else   begin i_req = 1'b1; i_rw = rw; i_addr = a; i_wdata = w; end
  endtask

  task automatic wait_ack(input bit p);
    int n;
    n = 0;
    ack_seen[p] = 1'b0;
    while (!ack_seen[p] && n < 20) begin
      advance();
      n++;
    end
    check_eq(p ? "d_ack_timeout" : "i_ack_timeout", ack_seen[p], 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((i_req || d_req || cyc < free_at) && n < 40) begin
      advance();
      n++;
    end
    check_eq("drain_timeout", (i_req || d_req || cyc < free_at), 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    logic [11:0] top;
    a   = $urandom;
    top = 12'h001;
    if ($urandom % 6 == 0) begin
      top = 12'($urandom);
      if (top == 12'h001) top = 12'h7FF;
    end
    a[31:20] = top;
    a[19:5]  = '0;
    a[4:2]   = 3'($urandom % 8);
    return a;
  endfunction

  initial begin
    int c, n;
    rst = 1'b1;
    i_req = 0; i_rw = 0; i_addr = 0; i_wdata = 0;
    d_req = 0; d_rw = 0; d_addr = 0; d_wdata = 0;
    sram_miso = 16'h0;
    sram_mem[{18'h2, 1'b0}] = 16'hBEEF; sram_mem[{18'h2, 1'b1}] = 16'hDEAD;
    ref_mem[{18'h2, 1'b0}]  = 16'hBEEF; ref_mem[{18'h2, 1'b1}]  = 16'hDEAD;

    repeat (3) advance();
    rst = 1'b0;

    // In-region read on port D
    c = cyc;
    issue(1'b1, 1'b0, 32'h0010_0008, 32'h0);
    wait_ack(1'b1);
    check_eq("dread_latency", ack_cyc[1] - c, 4);
    check_eq("dread_rdata", d_rdata, 32'hDEADBEEF);
    check_eq("dread_err", d_err, 1'b0);
    advance();

    // In-region write on port I
    cs_low_cnt = 0;
    c = cyc;
    issue(1'b0, 1'b1, 32'h0010_0004, 32'h1234_5678);
    wait_ack(1'b0);
    check_eq("iwrite_latency", ack_cyc[0] - c, 4);
    check_eq("iwrite_cs_low", cs_low_cnt, 2);
    check_eq("iwrite_rdata", i_rdata, 32'h0);
    advance();

    // Out-of-region read on port D
    cs_low_cnt = 0;
    c = cyc;
    issue(1'b1, 1'b0, 32'h0020_0000, 32'h0);
    wait_ack(1'b1);
    check_eq("oor_latency", ack_cyc[1] - c, 1);
    check_eq("oor_err", d_err, 1'b1);
    check_eq("oor_rdata", d_rdata, 32'h0);
    check_eq("oor_cs_low", cs_low_cnt, 0);
    advance();

    // Ties and back-to-back after reset
    rst = 1'b1; advance(); rst = 1'b0;
    ack_order.delete(); ack_times.delete();
    n = 0;
    while (ack_order.size() < 4 && n < 60) begin
      if (!i_req) issue(1'b0, 1'b0, 32'h0010_0008, 32'h0);
      if (!d_req) issue(1'b1, 1'b0, 32'h0010_0010, 32'h0);
      advance();
      n++;
    end
    check_eq("tie_count", ack_order.size(), 4);
    if (ack_order.size() >= 4) begin
      check_eq("tie_order0", ack_order[0], 1'b1);
      check_eq("tie_order1", ack_order[1], 1'b0);
      check_eq("tie_order2", ack_order[2], 1'b1);
      check_eq("tie_order3", ack_order[3], 1'b0);
      for (int j = 1; j < 4; j++) check_eq("tie_spacing", ack_times[j] - ack_times[j-1], 5);
    end
    drain();

    // Reset during HI, request held and completed afterwards
    issue(1'b1, 1'b0, 32'h0010_0008, 32'h0);
    n = 0;
    do begin advance(); n++; end
    while (!(cyc == grant_cyc + 2 && m_grant_port && cyc < free_at) && n < 20);
    rst = 1'b1; advance(); rst = 1'b0;
    check_eq("rst_cs_n", sram_cs_n, 1'b1);
    check_eq("rst_d_ack", d_ack, 1'b0);
    wait_ack(1'b1);
    check_eq("rst_reissue_rdata", d_rdata, 32'hDEADBEEF);
    drain();

    // Late contender: I rises during the LO state of a D transaction
    issue(1'b1, 1'b0, 32'h0010_0008, 32'h0);
    n = 0;
    do begin advance(); n++; end
    while (!(cyc == grant_cyc + 1 && m_grant_port && cyc < free_at) && n < 20);
    issue(1'b0, 1'b0, 32'h0010_0008, 32'h0);
    wait_ack(1'b1);
    c = ack_cyc[1];
    wait_ack(1'b0);
    check_eq("late_gap", ack_cyc[0] - c, 5);
    check_eq("late_rdata", i_rdata, 32'hDEADBEEF);
    drain();

    // Random traffic with occasional resets
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom % 150 == 0);
      if (!i_req && ack_cyc[0] != cyc && $urandom % 3 == 0)
        issue(1'b0, 1'($urandom), rand_addr(), $urandom);
      if (!d_req && ack_cyc[1] != cyc && $urandom % 3 == 0)
        issue(1'b1, 1'($urandom), rand_addr(), $urandom);
      advance();
    end
    rst = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
